// File: rtl/data_mem_responder.sv
// data_mem_responder: single-initiator word memory with a fixed number of
// wait states between request acceptance and the one-cycle ack pulse.
// Optional feature macro: DMEM_ALIGN_CHECK_EN. When it is defined, misaligned
// requests complete with err=1 and no access. When it is undefined, addr[1:0]
// is ignored and err stays 0.
module data_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic        err
);
    localparam int         AW        = $clog2(DEPTH);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_RESP    = 2'd2;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic          mis_q;
    logic          ack_q;
    logic          err_q;

    logic accept;
    logic resp_fire;
    logic wr_fire;
    logic rd_fire;
    logic addr_mis;
    logic unused_addr_bits;

    // A request is only looked at while idle; anything arriving while busy is dropped.
    assign accept    = (state_q == S_IDLE) && req;
    // The captured access is performed on the edge that leaves RESP; reset on
    // that same edge suppresses it, so an aborted write never lands.
    assign resp_fire = (state_q == S_RESP) && !rst;
    assign wr_fire   = resp_fire && we_q && !mis_q;
    assign rd_fire   = resp_fire && !we_q && !mis_q;

`ifdef DMEM_ALIGN_CHECK_EN
    assign addr_mis         = |addr[1:0];
    assign unused_addr_bits = &{1'b0, addr[31:AW+2]};
`else
    assign addr_mis         = 1'b0;
    assign unused_addr_bits = &{1'b0, addr[31:AW+2], addr[1:0]};
`endif

    // Next-state and wait-counter logic for the IDLE -> WAIT -> RESP sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    cnt_d   = WAIT_LOAD;
                    state_d = (WAIT_LOAD == 4'd0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request capture; this is plain datapath, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= we;
            idx_q   <= addr[AW+1:2];
            wdata_q <= wdata;
            be_q    <= be;
            mis_q   <= addr_mis;
        end
    end

    // Completion pulse and error qualifier, registered on the RESP exit edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ack_q <= resp_fire;
            err_q <= resp_fire && mis_q;
        end
    end

    // One byte-wide RAM per lane. Each lane holds its own read register, and
    // that register keeps its value until the next successful read.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_rd_q;

            // Byte-lane write, gated by the captured byte enable.
            always_ff @(posedge clk) begin
                if (wr_fire && be_q[gi]) begin
                    lane_mem[idx_q] <= wdata_q[8*gi +: 8];
                end
            end

            // Registered read of the whole word, independent of be.
            always_ff @(posedge clk) begin
                if (rst) begin
                    lane_rd_q <= 8'h00;
                end else if (rd_fire) begin
                    lane_rd_q <= lane_mem[idx_q];
                end
            end

            assign rdata[8*gi +: 8] = lane_rd_q;
        end
    endgenerate

    assign ack  = ack_q;
    assign err  = err_q;
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder. A transaction-level model predicts ack,
// busy, err and rdata every cycle; directed literals pin the model.
module tb_data_mem_responder;
    localparam int DEPTH = 256;
    localparam int W     = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic [31:0] rdata;
    logic        ack, busy, err;

    logic        req2 = 1'b0;
    logic        we2 = 1'b0;
    logic [31:0] addr2 = '0;
    logic [31:0] wdata2 = '0;
    logic [3:0]  be2 = '0;
    logic [31:0] rdata2;
    logic        ack2, busy2, err2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .be(be), .rdata(rdata), .ack(ack), .busy(busy), .err(err)
    );

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
        .be(be2), .rdata(rdata2), .ack(ack2), .busy(busy2), .err(err2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [7:0]  m_mem [DEPTH][4];
    bit          m_val [DEPTH][4];
    bit          m_started = 0;
    bit          m_pend = 0;
    bit          m_was_idle;
    longint      m_edge = 0;
    longint      m_done = 0;
    bit          p_we;
    int          p_idx;
    logic [31:0] p_wdata;
    logic [3:0]  p_be;
    bit          p_mis;
    bit          m_ack = 0, m_err = 0, m_busy = 0;
    logic [31:0] m_rd = '0;
    bit          m_rd_known = 1;

    // Each accepted request completes WAIT_CYCLES+1 edges later; the access
    // happens then.
    always @(posedge clk) begin
        if (rst) begin
            m_started  = 1;
            m_pend     = 0;
            m_ack      = 0;
            m_err      = 0;
            m_rd       = '0;
            m_rd_known = 1;
        end else begin
            m_was_idle = !m_pend;
            m_ack = 0;
            m_err = 0;
            if (m_pend && m_edge == m_done) begin
                m_pend = 0;
                m_ack  = 1;
                if (p_mis) begin
                    m_err = 1;
                end else if (p_we) begin
                    for (int b = 0; b < 4; b++) begin
                        if (p_be[b]) begin
                            m_mem[p_idx][b] = p_wdata[8*b +: 8];
                            m_val[p_idx][b] = 1;
                        end
                    end
                end else begin
                    m_rd_known = 1;
                    for (int b = 0; b < 4; b++) begin
                        m_rd[8*b +: 8] = m_mem[p_idx][b];
                        if (!m_val[p_idx][b]) m_rd_known = 0;
                    end
                end
            end
            if (m_was_idle && req) begin
                m_pend  = 1;
                m_done  = m_edge + W + 1;
                p_we    = we;
                p_idx   = int'((addr >> 2) % DEPTH);
                p_wdata = wdata;
                p_be    = be;
`ifdef DMEM_ALIGN_CHECK_EN
                p_mis   = (addr[1:0] != 2'b00);
`else
                p_mis   = 0;
`endif
            end
        end
        m_busy = m_pend;
        m_edge++;
    end

    // Compare the DUT against the model on every cycle after the first reset.
    always @(negedge clk) begin
        if (m_started) begin
            chk("cyc_ack", {31'b0, ack}, {31'b0, m_ack});
            chk("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
            chk("cyc_err", {31'b0, err}, {31'b0, m_err});
            if (m_rd_known) chk("cyc_rdata", rdata, m_rd);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b, output int lat, output logic [31:0] rd,
                       output logic e);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        lat = -1;
        rd = 'x;
        e = 1'bx;
        for (int i = 1; i <= 20 && lat < 0; i++) begin
            @(negedge clk);
            if (i == 1) req = 1'b0;
            if (ack === 1'b1) begin
                lat = i;
                rd  = rdata;
                e   = err;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL txn_timeout: got no ack expected ack addr %h", a);
        end
        $display("txn we=%0d addr=%h wdata=%h be=%b lat=%0d rdata=%h err=%b", w, a, d, b, lat, rd, e);
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        e;
        int          acks;

        repeat (3) @(negedge clk);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ack", {31'b0, ack}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Write then read, including the latency of the write.
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, e);
        chk("wr_latency", lat, 4);
        txn(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, e);
        chk("rd_10", rd, 32'hDEADBEEF);

        // Byte enables.
        txn(1'b1, 32'h30, 32'h11223344, 4'hF, lat, rd, e);
        txn(1'b1, 32'h30, 32'hAABBCCDD, 4'b0101, lat, rd, e);
        txn(1'b0, 32'h30, 32'h0, 4'h0, lat, rd, e);
        chk("rd_be_merge", rd, 32'h11BB33DD);

        // Wrap-around.
        txn(1'b1, 32'h400, 32'h5, 4'hF, lat, rd, e);
        txn(1'b0, 32'h000, 32'h0, 4'h3, lat, rd, e);
        chk("rd_wrap", rd, 32'h5);

        // be=0 write completes without changing memory.
        txn(1'b1, 32'h10, 32'h0, 4'h0, lat, rd, e);
        chk("be0_lat", lat, 4);
        txn(1'b0, 32'h10, 32'h0, 4'h0, lat, rd, e);
        chk("rd_be0", rd, 32'hDEADBEEF);

        // req pulses while busy are ignored.
        txn(1'b1, 32'h20, 32'h12345678, 4'hF, lat, rd, e);
        acks = 0;
        we = 1'b0; addr = 32'h20; be = 4'hF;
        for (int k = 0; k < 10; k++) begin
            req = (k == 0 || k == 2 || k == 3);
            @(negedge clk);
            if (ack === 1'b1) acks++;
        end
        req = 1'b0;
        chk("busy_ignore_acks", acks, 1);
        $display("txn busy-pulse read 0x20 acks=%0d rdata=%h", acks, rdata);

        // Reset during WAIT aborts a write.
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'hBADBAD00; be = 4'hF;
        @(negedge clk);
        req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_ack", {31'b0, ack}, 32'h0);
        rst = 1'b0;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ack === 1'b1) acks++;
        end
        chk("abort_no_ack", acks, 0);
        $display("txn aborted write 0x20 acks=%0d", acks);
        txn(1'b0, 32'h20, 32'h0, 4'h0, lat, rd, e);
        chk("rd_after_abort", rd, 32'h12345678);

        // Misaligned read.
        txn(1'b0, 32'h13, 32'h0, 4'h0, lat, rd, e);
        chk("mis_lat", lat, 4);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("mis_err", {31'b0, e}, 32'h1);
        chk("mis_rdata", rd, 32'h12345678);
`else
        chk("mis_err", {31'b0, e}, 32'h0);
        chk("mis_rdata", rd, 32'hDEADBEEF);
`endif

        // Zero-wait instance: req held for four edges gives two acks.
        acks = 0;
        req2 = 1'b1; we2 = 1'b1; addr2 = 32'h40; wdata2 = 32'h0F0F0F0F; be2 = 4'hF;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (j == 3) req2 = 1'b0;
            chk("w0_ack", {31'b0, ack2}, (j == 1 || j == 3) ? 32'h1 : 32'h0);
            chk("w0_busy", {31'b0, busy2}, (j == 0 || j == 2) ? 32'h1 : 32'h0);
            if (ack2 === 1'b1) acks++;
        end
        chk("w0_acks", acks, 2);
        $display("txn zero-wait held req acks=%0d", acks);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
